// File: rtl/rot_arbiter.sv
// rot_arbiter: round-robin arbiter sharing one 8-bit rotator across N_REQ requesters.
// Define ROT_ARB_STATS_EN to add saturating per-requester grant counters (grant_cnt).
module rot_arbiter #(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [3*N_REQ-1:0]   req_amt,
  input  logic [N_REQ-1:0]     req_dir,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id
`ifdef ROT_ARB_STATS_EN
  ,
  output logic [16*N_REQ-1:0]  grant_cnt
`endif
);
  logic [ID_W-1:0] ptr_q, ptr_d, gnt, rsp_id_q, rsp_id_d;
  logic            rsp_valid_q, rsp_valid_d, can_accept, xfer, dir;
  logic [7:0]      rsp_data_q, rsp_data_d, a, y;
  logic [2:0]      k;
  logic [15:0]     dd;
  // Scan downward so the lowest offset from ptr is written last and wins.
  always_comb begin
    gnt = ptr_q;
    for (int j = N_REQ - 1; j >= 0; j--)
      if (req_valid[(int'(ptr_q) + j) % N_REQ]) gnt = ID_W'((int'(ptr_q) + j) % N_REQ);
  end
  // Rotating the doubled byte keeps every bit: left takes the high half, right the low half.
  always_comb begin
    a   = req_data[8*gnt +: 8];
    k   = req_amt[3*gnt +: 3];
    dir = req_dir[gnt];
    dd  = dir ? ({a, a} >> k) : ({a, a} << k);
    y   = dir ? dd[7:0] : dd[15:8];
  end
  always_comb begin
    can_accept     = !rsp_valid_q || rsp_ready;
    xfer           = can_accept && |req_valid;
    req_ready      = '0;
    req_ready[gnt] = xfer;
    ptr_d          = xfer ? ((gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + 1'b1) : ptr_q;
    rsp_valid_d    = xfer || (rsp_valid_q && !rsp_ready);
    rsp_data_d     = xfer ? y : rsp_data_q;
    rsp_id_d       = xfer ? gnt : rsp_id_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
`ifdef ROT_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] cnt_q, cnt_d;
  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      cnt_d[i] = (req_ready[i] && cnt_q[i] != 16'hFFFF) ? cnt_q[i] + 16'd1 : cnt_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign grant_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_rot_arbiter.sv
// tb_rot_arbiter: directed checks of rotation, round-robin order, backpressure and async reset.
module tb_rot_arbiter;
  localparam int N = 4;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0, req_ready, req_dir = '0;
  logic [8*N-1:0] req_data = '0;
  logic [3*N-1:0] req_amt = '0;
  logic           rsp_valid, rsp_ready = 1'b1;
  logic [7:0]     rsp_data;
  logic [1:0]     rsp_id;
  int             checks = 0, errors = 0;
`ifdef ROT_ARB_STATS_EN
  logic [16*N-1:0] grant_cnt;
`endif
  rot_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amt(req_amt), .req_dir(req_dir),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef ROT_ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] k, input logic r);
    req_data[8*i +: 8] = d;
    req_amt[3*i +: 3]  = k;
    req_dir[i]         = r;
  endtask
  task automatic expect_rsp(input string tag, input logic [7:0] d, input logic [1:0] id);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_data"}, 32'(rsp_data), 32'(d));
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
  endtask
  initial begin
    logic [7:0] rr_data [4] = '{8'h11, 8'h44, 8'hCC, 8'h22};
    int         rr_id   [6] = '{0, 1, 2, 3, 0, 1};
    #12;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    set_req(0, 8'h81, 3'd1, 1'b0);
    req_valid = 4'b0001;
    #1 check("left_ready", 32'(req_ready), 32'b0001);
    tick();
    expect_rsp("left", 8'h03, 2'd0);
    req_valid = 4'b0100;
    set_req(2, 8'h81, 3'd1, 1'b1);
    tick();
    expect_rsp("right1", 8'hC0, 2'd2);
    set_req(2, 8'hA5, 3'd4, 1'b0);
    tick();
    expect_rsp("left4", 8'h5A, 2'd2);
    set_req(2, 8'hA5, 3'd4, 1'b1);
    tick();
    expect_rsp("right4", 8'h5A, 2'd2);
    set_req(2, 8'h3C, 3'd0, 1'b1);
    tick();
    expect_rsp("amt0", 8'h3C, 2'd2);
    req_valid = '0;
    tick();
    check("pop_valid", 32'(rsp_valid), 32'd0);
    check("pop_data_hold", 32'(rsp_data), 32'h3C);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 8'(8'h11 * (i + 1)), 3'(i), 1'b0);
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      tick();
      expect_rsp($sformatf("rr%0d", c), rr_data[rr_id[c]], 2'(rr_id[c]));
    end
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1 check($sformatf("bp_ready%0d", c), 32'(req_ready), 32'd0);
      tick();
      expect_rsp($sformatf("bp%0d", c), 8'h44, 2'd1);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_ready", 32'(req_ready), 32'b0100);
    tick();
    expect_rsp("bp_next", 8'hCC, 2'd2);
    tick();
    expect_rsp("wrap3", 8'h22, 2'd3);
    tick();
    expect_rsp("wrap0", 8'h11, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(rsp_valid), 32'd0);
    check("arst_data", 32'(rsp_data), 32'd0);
    check("arst_id", 32'(rsp_id), 32'd0);
    rst_n = 1'b1;
    req_valid = 4'b1001;
    tick();
    expect_rsp("post_rst", 8'h11, 2'd0);
`ifdef ROT_ARB_STATS_EN
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req_valid = 4'b0010;
    repeat (3) tick();
    check("cnt1_3", 32'(grant_cnt[31:16]), 32'd3);
    repeat (69997) tick();
    check("cnt1_sat", 32'(grant_cnt[31:16]), 32'hFFFF);
    check("cnt0", 32'(grant_cnt[15:0]), 32'd0);
    check("cnt2", 32'(grant_cnt[47:32]), 32'd0);
    check("cnt3", 32'(grant_cnt[63:48]), 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rot_arbiter.md
# rot_arbiter

Shares one 8-bit rotate unit between `N_REQ` requesters using round-robin arbitration. Each requester presents a byte, a rotate amount and a direction under a valid/ready handshake. The block grants one requester per cycle, rotates its byte, and returns the result through a single registered response port tagged with the requester index. It sits between the requesting engines and downstream consumers, so each client does not need its own rotator.

## Interface
- `N_REQ`, 4: number of requesters; legal range 2..8.
- `ID_W`, `$clog2(N_REQ)`: width of the response tag (derived; do not override).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in N_REQ: request i is presented.
- `req_ready` out N_REQ: request i is accepted this cycle; one-hot or zero.
- `req_data` in 8*N_REQ: byte for requester i is `[8i+7:8i]`.
- `req_amt` in 3*N_REQ: rotate amount 0..7 for requester i is `[3i+2:3i]`.
- `req_dir` in N_REQ: 0 = rotate left, 1 = rotate right.
- `rsp_valid` out 1: response register holds a result.
- `rsp_ready` in 1: downstream accepts the response.
- `rsp_data` out 8: rotated byte.
- `rsp_id` out ID_W: index of the requester that produced `rsp_data`.

## Operation
- Rotation is circular and never loses bits.
  - Left by k: `y = {a[7-k:0], a[7:8-k]}`.
  - Right by k: `y = {a[k-1:0], a[7:k]}`.
  - k = 0 returns `a` unchanged.
  - Left by k equals right by 8-k.
- `can_accept = !rsp_valid || rsp_ready`.
- Grant selection:
  - Search `req_valid` starting at pointer `ptr` upward, wrapping modulo N_REQ.
  - The first set bit wins.
  - `req_ready[g] = can_accept && req_valid[g]`; all other `req_ready` bits are 0.
- On an accepted transfer (`req_valid[g] && req_ready[g]`):
  - `rsp_data` <= rotate(`req_data[g]`, `req_amt[g]`, `req_dir[g]`).
  - `rsp_id` <= g; `rsp_valid` <= 1.
  - `ptr` <= (g+1) mod N_REQ.
- If there is no transfer and `rsp_valid && rsp_ready`, then `rsp_valid` <= 0. `rsp_data` and `rsp_id` hold their values.
- A response popped and a new grant in the same cycle gives back-to-back responses with `rsp_valid` staying 1.
- When nothing is granted, `ptr` holds.
- `req_ready` depends combinationally on `req_valid` and `rsp_ready`. Requesters must not derive `req_valid` from `req_ready`.
- Requesters hold `req_data`, `req_amt` and `req_dir` stable while `req_valid && !req_ready`.
- The response register holds `rsp_data` and `rsp_id` stable while `rsp_valid && !rsp_ready`.
- Reset values:
  - `rsp_valid` = 0, `rsp_data` = 8'h00, `rsp_id` = 0, `ptr` = 0.
  - `req_ready` = 0, since the response register is empty but no requester is valid during reset.
- Reset asserted mid-operation drops any pending response immediately, with no handshake.

## Timing
- Latency: a request accepted at edge k appears on `rsp_valid`/`rsp_data` after edge k, i.e. one cycle.
- Throughput: one result per cycle while `rsp_ready` = 1 and any request is valid.
- Backpressure: with `rsp_valid` = 1 and `rsp_ready` = 0, all `req_ready` bits are 0 and `ptr` holds.
- Fairness: with all N_REQ requesters continuously valid and `rsp_ready` = 1, the grants cycle through ptr, ptr+1, …. Every requester is served within N_REQ accepted transfers.
- Wrap-around: a grant to requester N_REQ-1 sets `ptr` to 0.
- The rotator and grant logic are combinational within one cycle. The only outputs that are not combinational are the response register and `ptr`.

## Configuration
- `ROT_ARB_STATS_EN` defined:
  - Adds output `grant_cnt`, width 16*N_REQ. Requester i's count is `[16i+15:16i]`.
  - Each count increments on every accepted transfer from requester i and saturates at 16'hFFFF.
  - All counts reset to 0 on `rst_n` low.
- `ROT_ARB_STATS_EN` undefined: the `grant_cnt` port and its counters are absent. All other behaviour is identical.

## Test plan
- **Left rotate.** Requester 0 sends `req_data` = 8'h81, amt = 1, dir = 0, with `rsp_ready` = 1. Required one cycle later: `rsp_data` = 8'h03, `rsp_id` = 0.
- **Right rotate and amount 4.**
  - Requester 2 sends 8'h81, amt = 1, dir = 1. Required: 8'hC0.
  - Then 8'hA5, amt = 4, in each direction. Required: 8'h5A both times.
  - Then amt = 0. Required: the input byte unchanged.
- **Round-robin.** All four requesters held valid and `rsp_ready` = 1 from reset. Required `rsp_id` sequence: 0, 1, 2, 3, 0, 1, with `rsp_valid` high every cycle.
- **Backpressure.** Hold `rsp_ready` = 0 for 5 cycles with requests pending. Required: `rsp_data`/`rsp_id` stable and all `req_ready` = 0. Then release: the held response is consumed and the next grant follows the stored `ptr`.
- **Reset mid-operation.** Pulse `rst_n` low asynchronously while `rsp_valid` = 1. Required: `rsp_valid`, `rsp_data` and `rsp_id` read 0 before the next clock edge. The first grant after release goes to the lowest-index valid requester.
- **Stats (`ROT_ARB_STATS_EN` defined).** Run 70000 grants to requester 1 only. Required: its count saturates at 16'hFFFF and all other counts stay 0.
